// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants for the 8-bit CPU controller: opcode map,
//                FSM state encoding and instruction-register field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Instruction register layout: opcode in the high nibble, address low
    localparam int IR_W        = 8;
    localparam int IR_OP_MSB   = 7;
    localparam int IR_OP_LSB   = 4;
    localparam int IR_ADDR_MSB = 3;
    localparam int IR_ADDR_LSB = 0;

    // Opcode map; 9..E are not listed and execute as NOP
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_STA = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Sequencer states
    localparam int              ST_W      = 3;
    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_FETCH  = 3'd1;
    localparam logic [ST_W-1:0] ST_DECODE = 3'd2;
    localparam logic [ST_W-1:0] ST_READ   = 3'd3;
    localparam logic [ST_W-1:0] ST_EXEC   = 3'd4;
    localparam logic [ST_W-1:0] ST_STORE  = 3'd5;
    localparam logic [ST_W-1:0] ST_HALT   = 3'd6;

    // Opcodes that fetch a memory operand before executing
    function automatic logic needs_operand(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl
//  Description : Fetch/decode/execute sequencer for the 8-bit CPU. Owns PC,
//                IR, the memory-wait timeout and all datapath load strobes;
//                drives the ALU's active-low op strobes and output enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IR_W-1:0]   mem_rdata,
    input  logic              mem_ready,
    input  logic              acc_zero,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              opnd_load,
    output logic              acc_load,
    output logic              acc_src,
    output logic              ealu_n,
    output logic              iadd_n,
    output logic              isub_n,
    output logic              iand_n,
    output logic              ior_n,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    localparam int               C_CNT_W     = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [C_CNT_W-1:0] C_WAIT_LAST = (WAIT_MAX > 0) ? C_CNT_W'(WAIT_MAX - 1) : '0;

    logic [ST_W-1:0]    state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [IR_W-1:0]    ir_q, ir_d;
    logic [C_CNT_W-1:0] wait_q, wait_d;
    logic               err_q, err_d;

    logic [3:0]         w_opcode;
    logic [ADDR_W-1:0]  w_ir_addr;
    logic               w_in_wait;
    logic               w_timeout;

    assign w_opcode  = ir_q[IR_OP_MSB:IR_OP_LSB];
    assign w_ir_addr = ir_q[IR_ADDR_LSB +: ADDR_W];
    assign w_in_wait = (state_q == ST_FETCH) || (state_q == ST_READ) || (state_q == ST_STORE);
    // Last permitted wait cycle passes with no ready: give up on this access
    assign w_timeout = (WAIT_MAX > 0) && w_in_wait && !mem_ready && (wait_q == C_WAIT_LAST);

    // State, PC, IR, wait counter and sticky error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Next-state and register update logic; wait counter is zero except while stalled
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        wait_d  = '0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_DECODE;
                end else if (w_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wait_d  = wait_q + C_CNT_W'(1);
                end
            end
            ST_DECODE: begin
                if (needs_operand(w_opcode)) begin
                    state_d = ST_READ;
                end else if (w_opcode == OP_STA) begin
                    state_d = ST_STORE;
                end else if (w_opcode == OP_HLT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    if ((w_opcode == OP_JMP) || ((w_opcode == OP_JZ) && acc_zero)) begin
                        pc_d = w_ir_addr;
                    end
                end
            end
            ST_READ: begin
                if (mem_ready) begin
                    state_d = ST_EXEC;
                end else if (w_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wait_d  = wait_q + C_CNT_W'(1);
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
            end
            ST_STORE: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end else if (w_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wait_d  = wait_q + C_CNT_W'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state; opnd_load alone also looks at mem_ready
    always_comb begin
        mem_addr  = pc_q;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        opnd_load = 1'b0;
        acc_load  = 1'b0;
        acc_src   = 1'b0;
        ealu_n    = 1'b1;
        iadd_n    = 1'b1;
        isub_n    = 1'b1;
        iand_n    = 1'b1;
        ior_n     = 1'b1;
        busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
        halted    = (state_q == ST_HALT);
        err       = err_q;
        case (state_q)
            ST_FETCH: begin
                mem_rd = 1'b1;
            end
            ST_READ: begin
                mem_rd    = 1'b1;
                mem_addr  = w_ir_addr;
                opnd_load = mem_ready;
            end
            ST_STORE: begin
                mem_wr   = 1'b1;
                mem_addr = w_ir_addr;
            end
            ST_EXEC: begin
                acc_load = 1'b1;
                if (w_opcode == OP_LDA) begin
                    acc_src = 1'b1;
                end else begin
                    ealu_n = 1'b0;
                    case (w_opcode)
                        OP_ADD:  iadd_n = 1'b0;
                        OP_SUB:  isub_n = 1'b0;
                        OP_AND:  iand_n = 1'b0;
                        OP_OR:   ior_n  = 1'b0;
                        default: ealu_n = 1'b1;
                    endcase
                end
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
